// File: rtl/ft601_wr_pingpong_buf_if.sv
// Producer and FT601 side bundle for the ping-pong write buffer.
// master = producer/FT601 driver, slave = buffer.
interface ft601_wr_pingpong_buf_if #(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 4096
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              wr_push;
    logic              writeable;
    logic              almost_unwriteable;
    logic [CNT_W-1:0]  wr_count;
    logic              overflow;
    logic              ft_txe_n;
    logic              ft_wr_n;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              readable;

    modport master (
        output wr_data, wr_en, wr_push, ft_txe_n, ft_wr_n,
        input  writeable, almost_unwriteable, wr_count, overflow,
        input  rd_data, rd_valid, rd_last, readable
    );

    modport slave (
        input  wr_data, wr_en, wr_push, ft_txe_n, ft_wr_n,
        output writeable, almost_unwriteable, wr_count, overflow,
        output rd_data, rd_valid, rd_last, readable
    );
endinterface

// File: rtl/ft601_wr_pingpong_buf.sv
// Two-bank ping-pong write buffer for the FT601, single clock domain.
// Optional idle-timeout seal: define FT601_WR_PINGPONG_TIMEOUT_EN.
module ft601_wr_pingpong_buf #(
    parameter int DATA_W  = 36,
    parameter int DEPTH   = 4096,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    ft601_wr_pingpong_buf_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        SEALED,
        DRAINING
    } bank_st_e;

    logic [DATA_W-1:0] mem [2*DEPTH];

    bank_st_e          state_q [2];
    bank_st_e          state_d [2];
    logic [CNT_W-1:0]  bank_cnt_q [2];
    logic [CNT_W-1:0]  bank_cnt_d [2];
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              writeable_q, writeable_d;
    logic              almost_q, almost_d;
    logic              overflow_q, overflow_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              readable_q, readable_d;

    logic              wr_acc;
    logic [CNT_W-1:0]  cnt_after;
    logic              to_seal;
    logic              seal;
    logic              beat;
    logic              rd_load;

    assign wr_acc    = bus.wr_en & writeable_q;
    assign cnt_after = wr_count_q + {{(CNT_W-1){1'b0}}, wr_acc};
    assign beat      = ~bus.ft_txe_n & ~bus.ft_wr_n & rd_valid_q;
    assign seal      = (cnt_after == CNT_W'(DEPTH))
                     | (bus.wr_push & (cnt_after != '0))
                     | to_seal;

`ifdef FT601_WR_PINGPONG_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (wr_acc)
            idle_d = '0;
        else if (idle_q != IDLE_W'(TIMEOUT))
            idle_d = idle_q + 1'b1;
        to_seal = (TIMEOUT != 0)
                && (idle_q == IDLE_W'(TIMEOUT))
                && (wr_count_q != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    assign to_seal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[{wb_q, wr_count_q[AW-1:0]}] <= bus.wr_data;
    end

    always_comb begin
        state_d    = state_q;
        bank_cnt_d = bank_cnt_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        wr_count_d = cnt_after;
        overflow_d = overflow_q | (bus.wr_en & ~writeable_q);
        rd_idx_d   = rd_idx_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        rd_load    = 1'b0;

        // fill side only touches bank[wb] while it is EMPTY/FILLING
        if (wr_acc)
            state_d[wb_q] = FILLING;
        if (seal) begin
            state_d[wb_q]    = SEALED;
            bank_cnt_d[wb_q] = cnt_after;
            wb_d             = ~wb_q;
            wr_count_d       = '0;
        end

        // drain side only touches bank[rb] while it is SEALED/DRAINING
        if (beat && rd_last_q) begin
            state_d[rb_q] = EMPTY;
            rb_d          = ~rb_q;
            rd_idx_d      = '0;
            rd_valid_d    = 1'b0;
            rd_last_d     = 1'b0;
        end else if (beat) begin
            state_d[rb_q] = DRAINING;
            rd_idx_d      = rd_idx_q + 1'b1;
            rd_load       = 1'b1;
        end else if (!rd_valid_q && state_q[rb_q] == SEALED) begin
            rd_load = 1'b1;
        end

        if (rd_load) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[{rb_q, rd_idx_d}];
            rd_last_d  = ({1'b0, rd_idx_d}
                          == bank_cnt_q[rb_q] - CNT_W'(1));
        end

        writeable_d = (state_d[wb_d] == EMPTY)
                    || (state_d[wb_d] == FILLING);
        almost_d    = writeable_d
                    && (wr_count_d >= CNT_W'(DEPTH - 1))
                    && (state_d[~wb_d] != EMPTY);
        readable_d  = (state_d[rb_d] == SEALED)
                    || (state_d[rb_d] == DRAINING);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= '{EMPTY, EMPTY};
            bank_cnt_q  <= '{default: '0};
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wr_count_q  <= '0;
            writeable_q <= 1'b1;
            almost_q    <= 1'b0;
            overflow_q  <= 1'b0;
            rd_idx_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            readable_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_cnt_q  <= bank_cnt_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wr_count_q  <= wr_count_d;
            writeable_q <= writeable_d;
            almost_q    <= almost_d;
            overflow_q  <= overflow_d;
            rd_idx_q    <= rd_idx_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
            readable_q  <= readable_d;
        end
    end

    assign bus.writeable          = writeable_q;
    assign bus.almost_unwriteable = almost_q;
    assign bus.wr_count           = wr_count_q;
    assign bus.overflow           = overflow_q;
    assign bus.rd_data            = rd_data_q;
    assign bus.rd_valid           = rd_valid_q;
    assign bus.rd_last            = rd_last_q;
    assign bus.readable           = readable_q;

endmodule

// File: tb/tb_ft601_wr_pingpong_buf.sv
// Directed scoreboard bench for ft601_wr_pingpong_buf (DEPTH=16).
// Timeout case follows FT601_WR_PINGPONG_TIMEOUT_EN.
module tb_ft601_wr_pingpong_buf;
    localparam int DW = 36;
    localparam int DP = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ft601_wr_pingpong_buf_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    ft601_wr_pingpong_buf #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .TIMEOUT(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   beats   = 0;
    int   fill_cnt = 0;
    int   base;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one accepted write; the model tracks where each bank ends
    task automatic write_word(input logic [DW-1:0] d, input logic push);
        exp_t e;
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        bus.wr_push = push;
        fill_cnt++;
        e.data = d;
        e.last = (fill_cnt == DP) || push;
        if (e.last) fill_cnt = 0;
        exp_q.push_back(e);
        step();
        bus.wr_en   = 1'b0;
        bus.wr_push = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20 && !bus.rd_valid; k++) step();
        chk(tag, bus.rd_valid, 1);
    endtask

    task automatic finish_drain(input string tag, input int b0, input int n);
        bus.ft_txe_n = 1'b0;
        bus.ft_wr_n  = 1'b0;
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) step();
        step(); step(); step();
        bus.ft_txe_n = 1'b1;
        bus.ft_wr_n  = 1'b1;
        step();
        chk({tag, "_beats"}, beats - b0, n);
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_readable"}, bus.readable, 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && !bus.ft_txe_n && !bus.ft_wr_n && bus.rd_valid) begin
            exp_t e;
            beats++;
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL beat_unexpected: observed %0h expected none",
                       bus.rd_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_data", bus.rd_data, e.data);
                chk("rd_last", bus.rd_last, e.last);
            end
        end
    end

    initial begin
        bus.wr_data  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_push  = 1'b0;
        bus.ft_txe_n = 1'b1;
        bus.ft_wr_n  = 1'b1;
        step(); step();
        chk("rst_writeable", bus.writeable, 1);
        chk("rst_almost", bus.almost_unwriteable, 0);
        chk("rst_wr_count", bus.wr_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_last", bus.rd_last, 0);
        chk("rst_readable", bus.readable, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        reset_n = 1'b1;
        step();
        chk("rel_writeable", bus.writeable, 1);

        // full bank seals, other bank still free
        for (int i = 0; i < 16; i++) write_word(DW'(i), 1'b0);
        chk("full_wr_count", bus.wr_count, 0);
        chk("full_writeable", bus.writeable, 1);
        chk("full_readable", bus.readable, 1);
        chk("full_almost", bus.almost_unwriteable, 0);
        base = beats;
        finish_drain("full", base, 16);

        // explicit push of a partial bank
        for (int i = 0; i < 5; i++) write_word(DW'(100 + i), i == 4);
        chk("push_wr_count", bus.wr_count, 0);
        chk("push_readable", bus.readable, 1);
        base = beats;
        finish_drain("push", base, 5);

        // push with nothing written is ignored
        bus.wr_push = 1'b1;
        step();
        bus.wr_push = 1'b0;
        step();
        chk("push0_readable", bus.readable, 0);
        chk("push0_writeable", bus.writeable, 1);

        // both banks full, FT held off
        for (int i = 0; i < 31; i++) write_word(DW'(200 + i), 1'b0);
        chk("bp_almost31", bus.almost_unwriteable, 1);
        chk("bp_writeable31", bus.writeable, 1);
        write_word(DW'(231), 1'b0);
        chk("bp_writeable32", bus.writeable, 0);
        chk("bp_almost32", bus.almost_unwriteable, 0);
        chk("bp_overflow0", bus.overflow, 0);
        bus.wr_en   = 1'b1;
        bus.wr_data = DW'(999);
        step();
        bus.wr_en = 1'b0;
        chk("bp_overflow1", bus.overflow, 1);
        chk("bp_wr_count", bus.wr_count, 0);
        base = beats;
        finish_drain("bp", base, 32);
        chk("bp_writeable_after", bus.writeable, 1);

        // continuous stream while draining
        base = beats;
        bus.ft_txe_n = 1'b0;
        bus.ft_wr_n  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 50 && !bus.writeable; k++) step();
            write_word(DW'(300 + i), 1'b0);
        end
        finish_drain("stream", base, 64);

        // async reset in the middle of a burst
        for (int i = 0; i < 10; i++) write_word(DW'(400 + i), i == 9);
        bus.ft_txe_n = 1'b0;
        bus.ft_wr_n  = 1'b0;
        wait_valid("mid_valid");
        step(); step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rd_valid", bus.rd_valid, 0);
        chk("mid_readable", bus.readable, 0);
        chk("mid_rd_data", bus.rd_data, 0);
        chk("mid_rd_last", bus.rd_last, 0);
        chk("mid_overflow", bus.overflow, 0);
        chk("mid_writeable", bus.writeable, 1);
        exp_q.delete();
        fill_cnt = 0;
        step(); step();
        reset_n = 1'b1;
        base = beats;
        for (int k = 0; k < 6; k++) step();
        chk("mid_no_beats", beats - base, 0);
        chk("mid_rel_readable", bus.readable, 0);
        bus.ft_txe_n = 1'b1;
        bus.ft_wr_n  = 1'b1;
        step();

        for (int i = 0; i < 3; i++) write_word(DW'(500 + i), 1'b0);
`ifdef FT601_WR_PINGPONG_TIMEOUT_EN
        for (int k = 0; k < 30 && !bus.readable; k++) step();
        chk("to_readable", bus.readable, 1);
        chk("to_wr_count", bus.wr_count, 0);
`else
        for (int k = 0; k < 100; k++) step();
        chk("noto_readable", bus.readable, 0);
        chk("noto_wr_count", bus.wr_count, 3);
        bus.wr_push = 1'b1;
        step();
        bus.wr_push = 1'b0;
        chk("noto_push_readable", bus.readable, 1);
`endif
        if (exp_q.size() != 0) exp_q[exp_q.size()-1].last = 1'b1;
        fill_cnt = 0;
        base = beats;
        finish_drain("idle", base, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
